// File: rtl/axis_rr_switch.sv
// N-to-1 AXI-Stream switch with round-robin grant. A channel holds the output
// until TLAST (packet mode) or an idle timeout / beat limit (stream mode).
module axis_rr_switch #(
    parameter int DATA_WIDTH   = 512,
    parameter int CHANNELS     = 4,
    parameter int PACKET_MODE  = 1,
    parameter int IDLE_TIMEOUT = 128,
    parameter int MAX_BEATS    = 0,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic [CHANNELS-1:0]            AXIS_IN_TLAST,
    input  logic [CHANNELS-1:0]            AXIS_IN_TVALID,
    output logic [CHANNELS-1:0]            AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0]          AXIS_OUT_TDATA,
    output logic                           AXIS_OUT_TLAST,
    output logic [CW-1:0]                  AXIS_OUT_TID,
    output logic                           AXIS_OUT_TVALID,
    input  logic                           AXIS_OUT_TREADY,
    output logic                           active,
    output logic [CW-1:0]                  active_channel
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q;
    logic [CW-1:0]   grant_q, rr_ptr_q, rr_ptr_d;
    logic [15:0]     idle_cnt_q, beat_cnt_q;

    logic            hit;
    logic [CW-1:0]   hit_idx;
    logic            locked, sel_valid, sel_last, beat;
    logic            idle_rel, beat_rel, release_now;
    logic [DATA_WIDTH-1:0] sel_data;

    // Round-robin scan starting at rr_ptr with wrap-around
    always_comb begin
        int idx;
        idx     = 0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!hit && AXIS_IN_TVALID[idx]) begin
                hit     = 1'b1;
                hit_idx = CW'(idx);
            end
        end
        rr_ptr_d = (hit_idx == CW'(CHANNELS-1)) ? '0 : hit_idx + 1'b1;
    end

    assign locked    = (state_q == LOCKED);
    assign sel_valid = AXIS_IN_TVALID[grant_q];
    assign sel_last  = AXIS_IN_TLAST[grant_q];
    assign sel_data  = AXIS_IN_TDATA[grant_q*DATA_WIDTH +: DATA_WIDTH];

    assign AXIS_OUT_TVALID = locked & sel_valid;
    assign AXIS_OUT_TLAST  = locked & sel_last;
    assign AXIS_OUT_TDATA  = locked ? sel_data : '0;
    assign AXIS_OUT_TID    = grant_q;
    assign active          = locked;
    assign active_channel  = grant_q;

    always_comb begin
        AXIS_IN_TREADY = '0;
        if (locked) AXIS_IN_TREADY[grant_q] = AXIS_OUT_TREADY;
    end

    assign beat        = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
    assign idle_rel    = !sel_valid && (idle_cnt_q == 16'(IDLE_TIMEOUT-1));
    assign beat_rel    = (MAX_BEATS != 0) && beat && (beat_cnt_q == 16'(MAX_BEATS-1));
    assign release_now = (PACKET_MODE != 0) ? (beat & sel_last) : (idle_rel | beat_rel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        grant_q    <= hit_idx;
                        rr_ptr_q   <= rr_ptr_d;
                        idle_cnt_q <= '0;
                        beat_cnt_q <= '0;
                        state_q    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (release_now) state_q <= IDLE;
                    // Counters hold at all-ones rather than wrap on pathological idle
                    if (sel_valid)                  idle_cnt_q <= '0;
                    else if (idle_cnt_q != 16'hFFFF) idle_cnt_q <= idle_cnt_q + 16'd1;
                    if (beat && beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_switch.sv
// Randomized bench: a packet-mode and a stream-mode switch driven by AXIS
// producers, each compared every cycle against a rule-level reference model.
module tb_axis_rr_switch;

    localparam int DW = 16;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [CH*DW-1:0] in_data  [2];
    logic [CH-1:0]    in_last  [2];
    logic [CH-1:0]    in_valid [2];
    logic [CH-1:0]    in_ready [2];
    logic [DW-1:0]    o_data   [2];
    logic             o_last   [2];
    logic [1:0]       o_tid    [2];
    logic             o_valid  [2];
    logic             o_ready  [2];
    logic             o_act    [2];
    logic [1:0]       o_ach    [2];

    axis_rr_switch #(.DATA_WIDTH(DW), .CHANNELS(CH), .PACKET_MODE(1),
                     .IDLE_TIMEOUT(128), .MAX_BEATS(0)) u_pkt (
        .clk(clk), .reset(reset),
        .AXIS_IN_TDATA(in_data[0]), .AXIS_IN_TLAST(in_last[0]),
        .AXIS_IN_TVALID(in_valid[0]), .AXIS_IN_TREADY(in_ready[0]),
        .AXIS_OUT_TDATA(o_data[0]), .AXIS_OUT_TLAST(o_last[0]),
        .AXIS_OUT_TID(o_tid[0]), .AXIS_OUT_TVALID(o_valid[0]),
        .AXIS_OUT_TREADY(o_ready[0]), .active(o_act[0]), .active_channel(o_ach[0]));

    axis_rr_switch #(.DATA_WIDTH(DW), .CHANNELS(CH), .PACKET_MODE(0),
                     .IDLE_TIMEOUT(4), .MAX_BEATS(8)) u_str (
        .clk(clk), .reset(reset),
        .AXIS_IN_TDATA(in_data[1]), .AXIS_IN_TLAST(in_last[1]),
        .AXIS_IN_TVALID(in_valid[1]), .AXIS_IN_TREADY(in_ready[1]),
        .AXIS_OUT_TDATA(o_data[1]), .AXIS_OUT_TLAST(o_last[1]),
        .AXIS_OUT_TID(o_tid[1]), .AXIS_OUT_TVALID(o_valid[1]),
        .AXIS_OUT_TREADY(o_ready[1]), .active(o_act[1]), .active_channel(o_ach[1]));

    // Per-DUT mode settings as seen by the model
    int pkt_mode [2] = '{1, 0};
    int timeout  [2] = '{128, 4};
    int max_bt   [2] = '{0, 8};

    // Model state: owner channel (-1 = nobody), next channel to favour, streaks
    int owner   [2];
    int favour  [2];
    int idle_run[2];
    int burst   [2];
    int last_owner[2];

    // Producers: hold a beat until it is accepted
    logic [DW-1:0] p_data [2][CH];
    bit            p_val  [2][CH];
    bit            p_last [2][CH];
    bit            p_hold [2][CH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; favour[d] = 0; idle_run[d] = 0; burst[d] = 0; last_owner[d] = 0;
            for (int c = 0; c < CH; c++) p_hold[d][c] = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                in_data[d][c*DW +: DW] = p_data[d][c];
                in_last[d][c]          = p_last[d][c];
                in_valid[d][c]         = p_val[d][c];
            end
        end
    endtask

    // Compare one DUT against the model, then advance the model over the edge
    task automatic check_and_step(input int d);
        logic          e_valid, e_last;
        logic [DW-1:0] e_data;
        logic [CH-1:0] e_ready;
        int            g;
        bit            accepted, rel;
        g       = (owner[d] >= 0) ? owner[d] : 0;
        e_valid = (owner[d] >= 0) && p_val[d][g];
        e_last  = (owner[d] >= 0) && p_last[d][g];
        e_data  = (owner[d] >= 0) ? p_data[d][g] : '0;
        e_ready = '0;
        if (owner[d] >= 0 && o_ready[d]) e_ready[g] = 1'b1;

        chk($sformatf("d%0d.tvalid", d), 64'(o_valid[d]), 64'(e_valid));
        chk($sformatf("d%0d.tdata", d),  64'(o_data[d]),  64'(e_data));
        chk($sformatf("d%0d.tlast", d),  64'(o_last[d]),  64'(e_last));
        chk($sformatf("d%0d.tready", d), 64'(in_ready[d]), 64'(e_ready));
        chk($sformatf("d%0d.active", d), 64'(o_act[d]),   64'(owner[d] >= 0));
        chk($sformatf("d%0d.achan", d),  64'(o_ach[d]),   64'(last_owner[d]));
        if (e_valid) chk($sformatf("d%0d.tid", d), 64'(o_tid[d]), 64'(g));

        for (int c = 0; c < CH; c++)
            p_hold[d][c] = p_val[d][c] && !e_ready[c];

        accepted = e_valid && o_ready[d];
        if (reset) begin
            owner[d] = -1; favour[d] = 0; idle_run[d] = 0; burst[d] = 0; last_owner[d] = 0;
        end else if (owner[d] < 0) begin
            for (int k = 0; k < CH; k++) begin
                int c;
                c = (favour[d] + k) % CH;
                if (owner[d] < 0 && p_val[d][c]) begin
                    owner[d] = c; last_owner[d] = c;
                    favour[d] = (c + 1) % CH;
                    idle_run[d] = 0; burst[d] = 0;
                end
            end
        end else if (pkt_mode[d] != 0) begin
            if (accepted && p_last[d][g]) owner[d] = -1;
        end else begin
            rel = 1'b0;
            if (p_val[d][g]) idle_run[d] = 0;
            else begin
                idle_run[d]++;
                if (idle_run[d] >= timeout[d]) rel = 1'b1;
            end
            if (accepted) begin
                burst[d]++;
                if (max_bt[d] != 0 && burst[d] >= max_bt[d]) rel = 1'b1;
            end
            if (rel) owner[d] = -1;
        end
    endtask

    task automatic run_phase(input int cycles, input logic [CH-1:0] mask,
                             input int vpct, input int lpct, input int rpct, input int rpct_rst);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            reset = (int'($urandom_range(99)) < rpct_rst);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    if (!p_hold[d][c]) begin
                        p_val[d][c]  = mask[c] && (int'($urandom_range(99)) < vpct);
                        p_last[d][c] = (int'($urandom_range(99)) < lpct);
                        p_data[d][c] = DW'($urandom);
                    end
                end
                o_ready[d] = (int'($urandom_range(99)) < rpct);
            end
            drive_inputs();
            #1;
            for (int d = 0; d < 2; d++) check_and_step(d);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            o_ready[d] = 1'b1;
            for (int c = 0; c < CH; c++) begin
                p_val[d][c] = 1'b0; p_last[d][c] = 1'b0; p_data[d][c] = '0;
            end
        end
        drive_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state with a requester present: nothing may leak through
        p_val[0][2] = 1'b1; p_data[0][2] = 16'hBEEF; p_last[0][2] = 1'b1;
        p_val[1][2] = 1'b1; p_data[1][2] = 16'hBEEF; p_last[1][2] = 1'b1;
        drive_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d.tvalid", d), 64'(o_valid[d]), 64'(0));
            chk($sformatf("rst%0d.tdata", d),  64'(o_data[d]),  64'(0));
            chk($sformatf("rst%0d.tready", d), 64'(in_ready[d]), 64'(0));
            chk($sformatf("rst%0d.tid", d),    64'(o_tid[d]),   64'(0));
            chk($sformatf("rst%0d.active", d), 64'(o_act[d]),   64'(0));
            p_hold[d][2] = 1'b1;
        end

        run_phase(40,  4'b0100, 100, 33, 100, 0);  // lone channel, short packets
        run_phase(60,  4'b1111, 100, 100, 100, 0); // all channels, 1-beat packets
        run_phase(60,  4'b0010, 100, 25, 50, 0);   // backpressure
        run_phase(200, 4'b1001, 20, 30, 100, 0);   // sparse traffic, idle timeouts
        run_phase(200, 4'b0011, 100, 10, 100, 0);  // continuous, beat limit
        run_phase(600, 4'b1111, 60, 30, 70, 3);    // mixed with reset mid-transfer

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
